// File: rtl/acc_pipe_param.sv
// Two-stage pipelined 4-2-1 fixed-point neural network with valid/ready flow control.
// Stage 1 holds the hidden neurons H1/H2, stage 2 holds the output neuron result Y.
module acc_pipe_param #(
  parameter int DW   = 8,
  parameter int FRAC = 7,
  parameter int XMIN = -127,
  parameter int XMAX = 127,
  parameter int ACT  = 0,
  parameter logic signed [DW-1:0]   N1_W1   = DW'(-115),
  parameter logic signed [DW-1:0]   N1_W2   = DW'(1),
  parameter logic signed [DW-1:0]   N1_W3   = DW'(-105),
  parameter logic signed [DW-1:0]   N1_W4   = DW'(16),
  parameter logic signed [2*DW-1:0] N1_BIAS = (2*DW)'(12571),
  parameter logic signed [DW-1:0]   N2_W1   = DW'(103),
  parameter logic signed [DW-1:0]   N2_W2   = DW'(-22),
  parameter logic signed [DW-1:0]   N2_W3   = DW'(32),
  parameter logic signed [DW-1:0]   N2_W4   = DW'(-56),
  parameter logic signed [2*DW-1:0] N2_BIAS = (2*DW)'(-8139),
  parameter logic signed [DW-1:0]   N3_W1   = DW'(75),
  parameter logic signed [DW-1:0]   N3_W2   = DW'(-85),
  parameter logic signed [2*DW-1:0] N3_BIAS = (2*DW)'(10182)
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic signed [DW-1:0] X1,
  input  logic signed [DW-1:0] X2,
  input  logic signed [DW-1:0] X3,
  input  logic signed [DW-1:0] X4,
  input  logic                 valid,
  output logic                 ready,
  output logic signed [DW-1:0] Y,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [15:0]          out_count
);

  // Four DW x DW products plus a 2*DW bias always fit in 2*DW+3 bits.
  localparam int AW = 2*DW + 3;
  localparam logic signed [AW-1:0] LO = AW'(XMIN);
  localparam logic signed [AW-1:0] HI = AW'(XMAX);

  function automatic logic signed [DW-1:0] neuron(
    input logic signed [DW-1:0]   a, b, c, d,
    input logic signed [DW-1:0]   wa, wb, wc, wd,
    input logic signed [2*DW-1:0] bias
  );
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] r;
    acc = AW'(bias) + AW'(a) * AW'(wa) + AW'(b) * AW'(wb)
        + AW'(c) * AW'(wc) + AW'(d) * AW'(wd);
    r = acc >>> FRAC;
    if (ACT == 1 && r[AW-1]) r = '0;
    if (r < LO)      r = LO;
    else if (r > HI) r = HI;
    return r[DW-1:0];
  endfunction

  logic                 v1, v2;
  logic signed [DW-1:0] h1, h2;
  logic signed [DW-1:0] n1, n2, n3;
  logic                 load1, adv2;

  assign n1 = neuron(X1, X2, X3, X4, N1_W1, N1_W2, N1_W3, N1_W4, N1_BIAS);
  assign n2 = neuron(X1, X2, X3, X4, N2_W1, N2_W2, N2_W3, N2_W4, N2_BIAS);
  assign n3 = neuron(h1, h2, '0, '0, N3_W1, N3_W2, '0, '0, N3_BIAS);

  // Stage 1 can always drain when stage 2 is empty or being emptied this cycle.
  assign ready     = ~v1 | ~v2 | ready_out;
  assign load1     = valid & ready;
  assign adv2      = v1 & (~v2 | ready_out);
  assign valid_out = v2;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      h1        <= '0;
      h2        <= '0;
      Y         <= '0;
      out_count <= '0;
    end else begin
      if (load1) begin
        v1 <= 1'b1;
        h1 <= n1;
        h2 <= n2;
      end else if (adv2) begin
        v1 <= 1'b0;
      end

      if (adv2) begin
        v2 <= 1'b1;
        Y  <= n3;
      end else if (ready_out) begin
        v2 <= 1'b0;
      end

      if (v2 & ready_out) out_count <= out_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_acc_pipe_param.sv
// Randomized bench for acc_pipe_param: integer reference network, output scoreboard,
// flow-control scenarios, counter wrap and asynchronous reset.
module tb_acc_pipe_param;

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic signed [7:0] X1 = '0, X2 = '0, X3 = '0, X4 = '0;
  logic              valid = 1'b0;
  logic              ready_out = 1'b1;
  logic              ready, valid_out;
  logic signed [7:0] Y;
  logic [15:0]       out_count;
  logic              ready_r, valid_out_r;
  logic signed [7:0] Y_r;
  logic [15:0]       out_count_r;

  acc_pipe_param #(.ACT(0)) dut (
    .clk(clk), .arst(arst), .X1(X1), .X2(X2), .X3(X3), .X4(X4),
    .valid(valid), .ready(ready), .Y(Y), .valid_out(valid_out),
    .ready_out(ready_out), .out_count(out_count)
  );

  acc_pipe_param #(.ACT(1)) dut_r (
    .clk(clk), .arst(arst), .X1(X1), .X2(X2), .X3(X3), .X4(X4),
    .valid(valid), .ready(ready_r), .Y(Y_r), .valid_out(valid_out_r),
    .ready_out(ready_out), .out_count(out_count_r)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int model_cnt = 0;
  logic signed [7:0] exp_q[$];
  logic signed [7:0] got_q[$];

  function automatic int floor_div(int a, int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int neuron(int a, int b, int c, int d, int wa, int wb, int wc, int wd,
                                int bias, bit act);
    int r;
    r = floor_div(a*wa + b*wb + c*wc + d*wd + bias, 128);
    if (act && r < 0) r = 0;
    if (r < -127) r = -127;
    if (r > 127) r = 127;
    return r;
  endfunction

  function automatic int model_y(int a, int b, int c, int d, bit act);
    int h1, h2;
    h1 = neuron(a, b, c, d, -115, 1, -105, 16, 12571, act);
    h2 = neuron(a, b, c, d, 103, -22, 32, -56, -8139, act);
    return neuron(h1, h2, 0, 0, 75, -85, 0, 0, 10182, act);
  endfunction

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Entered and left at a falling edge; records handshakes seen before the rising edge.
  task automatic cycle(input bit v, input int a, input int b, input int c, input int d,
                       input bit ro, output bit rdy, output bit del);
    valid = v; X1 = 8'(a); X2 = 8'(b); X3 = 8'(c); X4 = 8'(d); ready_out = ro;
    #1;
    rdy = ready;
    del = valid_out && ro;
    if (v && ready) exp_q.push_back(8'(model_y(a, b, c, d, 1'b0)));
    if (del) begin
      got_q.push_back(Y);
      model_cnt = (model_cnt + 1) % 65536;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit r, d;
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 0, 1'b1, r, d);
  endtask

  task automatic test_reset();
    valid = 1'b0; ready_out = 1'b1; arst = 1'b1;
    #1;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out got=%b want=0", valid_out); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
    total++; if (Y !== 8'sd0) begin bad++; $display("FAIL reset_y got=%0d want=0", Y); end
    total++; if (out_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", out_count); end
    @(negedge clk);
    arst = 1'b0;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", ready); end
    @(negedge clk);
  endtask

  task automatic test_vectors();
    bit r, d;
    // zero input: Y saturates from 179 to 127
    cycle(1'b1, 0, 0, 0, 0, 1'b1, r, d);
    total++; if (dut.h1 !== 8'sd98) begin bad++; $display("FAIL zero_h1 got=%0d want=98", dut.h1); end
    total++; if (dut.h2 !== -8'sd64) begin bad++; $display("FAIL zero_h2 got=%0d want=-64", dut.h2); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL zero_latency got=%b want=0", valid_out); end
    cycle(1'b0, 0, 0, 0, 0, 1'b1, r, d);
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL zero_valid_out got=%b want=1", valid_out); end
    total++; if (Y !== 8'sd127) begin bad++; $display("FAIL zero_y got=%0d want=127", Y); end
    cycle(1'b0, 0, 0, 0, 0, 1'b1, r, d);
    total++; if (out_count !== 16'd1) begin bad++; $display("FAIL zero_count got=%0d want=1", out_count); end
    // X1 = 127 on both activation modes
    cycle(1'b1, 127, 0, 0, 0, 1'b1, r, d);
    total++; if (dut.h1 !== -8'sd16) begin bad++; $display("FAIL x127_h1 got=%0d want=-16", dut.h1); end
    total++; if (dut.h2 !== 8'sd38) begin bad++; $display("FAIL x127_h2 got=%0d want=38", dut.h2); end
    total++; if (dut_r.h1 !== 8'sd0) begin bad++; $display("FAIL relu_h1 got=%0d want=0", dut_r.h1); end
    total++; if (dut_r.h2 !== 8'sd38) begin bad++; $display("FAIL relu_h2 got=%0d want=38", dut_r.h2); end
    cycle(1'b0, 0, 0, 0, 0, 1'b1, r, d);
    total++; if (Y !== 8'sd44) begin bad++; $display("FAIL x127_y got=%0d want=44", Y); end
    total++; if (Y_r !== 8'sd54) begin bad++; $display("FAIL relu_y got=%0d want=54", Y_r); end
    idle(2);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL vec_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL vec_y[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit r, d;
    int start_cnt;
    start_cnt = model_cnt;
    for (int i = 0; i < 8; i++) begin
      cycle(i < 4, rnd8(), rnd8(), rnd8(), rnd8(), 1'b1, r, d);
      if (i < 4) begin
        total++; if (r !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, r); end
      end
      total++; if (d !== (i >= 2 && i <= 5)) begin bad++; $display("FAIL b2b_deliver[%0d] got=%b want=%b", i, d, (i >= 2 && i <= 5)); end
    end
    total++; if (out_count !== 16'(start_cnt + 4)) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", out_count, start_cnt + 4); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_size got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_y[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit r, d;
    int acc_n;
    int s[3][4];
    for (int i = 0; i < 3; i++) for (int j = 0; j < 4; j++) s[i][j] = rnd8();
    acc_n = 0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, s[i][0], s[i][1], s[i][2], s[i][3], 1'b0, r, d);
      if (r) acc_n++;
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, s[2][0], s[2][1], s[2][2], s[2][3], 1'b0, r, d);
      if (r) acc_n++;
      total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", k, valid_out); end
      total++; if (Y !== 8'(model_y(s[0][0], s[0][1], s[0][2], s[0][3], 1'b0))) begin
        bad++; $display("FAIL bp_hold_y[%0d] got=%0d want=%0d", k, Y, model_y(s[0][0], s[0][1], s[0][2], s[0][3], 1'b0));
      end
    end
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", ready); end
    total++; if (acc_n != 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", acc_n); end
    @(negedge clk);
    cycle(1'b1, s[2][0], s[2][1], s[2][2], s[2][3], 1'b1, r, d);
    idle(4);
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL bp_results got=%0d want=3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      total++; if (got_q[i] !== 8'(model_y(s[i][0], s[i][1], s[i][2], s[i][3], 1'b0))) begin
        bad++; $display("FAIL bp_y[%0d] got=%0d want=%0d", i, got_q[i], model_y(s[i][0], s[i][1], s[i][2], s[i][3], 1'b0));
      end
    end
    total++; if (out_count !== 16'(model_cnt)) begin bad++; $display("FAIL bp_count got=%0d want=%0d", out_count, model_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    bit r, d;
    for (int i = 0; i < 400; i++)
      cycle(bit'($urandom_range(0, 1)), rnd8(), rnd8(), rnd8(), rnd8(),
            $urandom_range(0, 3) != 0, r, d);
    idle(4);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_size got=%0d want=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_y[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]); end
    end
    total++; if (out_count !== 16'(model_cnt)) begin bad++; $display("FAIL rnd_count got=%0d want=%0d", out_count, model_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap_and_reset();
    bit r, d;
    int n, guard;
    arst = 1'b1; valid = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    model_cnt = 0; got_q.delete(); exp_q.delete();
    valid = 1'b1; ready_out = 1'b1; X1 = '0; X2 = '0; X3 = '0; X4 = '0;
    n = 0; guard = 0;
    while (n < 65535 && guard < 70000) begin
      #1;
      if (valid_out && ready_out) n++;
      @(negedge clk);
      guard++;
    end
    total++; if (n != 65535) begin bad++; $display("FAIL wrap_timeout got=%0d want=65535", n); end
    total++; if (out_count !== 16'd65535) begin bad++; $display("FAIL wrap_max got=%0d want=65535", out_count); end
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL wrap_stream got=%b want=1", valid_out); end
    @(negedge clk);
    total++; if (out_count !== 16'd0) begin bad++; $display("FAIL wrap_zero got=%0d want=0", out_count); end
    // fill both stages, then reset mid-flight
    ready_out = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", ready); end
    arst = 1'b1; valid = 1'b0;
    #1;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL arst_valid_out got=%b want=0", valid_out); end
    total++; if (out_count !== 16'd0) begin bad++; $display("FAIL arst_count got=%0d want=0", out_count); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b want=1", ready); end
    total++; if (dut.h1 !== 8'sd0) begin bad++; $display("FAIL arst_h1 got=%0d want=0", dut.h1); end
    @(negedge clk);
    arst = 1'b0;
    model_cnt = 0;
    idle(3);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL stale_results got=%0d want=0", got_q.size()); end
    cycle(1'b1, 127, 0, 0, 0, 1'b1, r, d);
    idle(3);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL fresh_size got=%0d want=1", got_q.size()); end
    if (got_q.size() > 0) begin
      total++; if (got_q[0] !== 8'sd44) begin bad++; $display("FAIL fresh_y got=%0d want=44", got_q[0]); end
    end
    total++; if (out_count !== 16'd1) begin bad++; $display("FAIL fresh_count got=%0d want=1", out_count); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_pipe_param.md
ACC_PIPE_PARAM -- requirements
Module: acc_pipe_param

Interface
REQ-001 SHALL have parameter DW, default 8, signed data width of X1..X4, hidden values and Y.
REQ-002 SHALL have parameter FRAC, default 7, arithmetic right-shift applied to every neuron accumulator.
REQ-003 SHALL have parameters XMIN/XMAX, default -127/127, signed saturation bounds for every neuron output.
REQ-004 SHALL have parameter ACT, default 0, activation mode: 0 = linear saturate, 1 = ReLU then saturate.
REQ-005 SHALL have parameters N1_W1..W4, default -115/1/-105/16, and N1_BIAS, default 12571, for hidden neuron 1.
REQ-006 SHALL have parameters N2_W1..W4, default 103/-22/32/-56, and N2_BIAS, default -8139, for hidden neuron 2.
REQ-007 SHALL have parameters N3_W1/W2, default 75/-85, and N3_BIAS, default 10182, for the output neuron; weights are DW-bit signed, biases 2*DW-bit signed.
REQ-008 clk  input  1  single clock, rising edge.
REQ-009 arst  input  1  reset, asynchronous, active-high.
REQ-010 X1, X2, X3, X4  input  DW  signed input sample.
REQ-011 valid  input  1  input sample present.
REQ-012 ready  output  1  block accepts the sample this cycle.
REQ-013 Y  output  DW  signed network result.
REQ-014 valid_out  output  1  Y holds a result.
REQ-015 ready_out  input  1  downstream accepts Y.
REQ-016 out_count  output  16  number of results delivered.

Function
REQ-017 Neuron: acc = sum(Xi*Wi) + sign-extended bias in 2*DW+3 bits (no overflow); r = acc >>> FRAC (floor); if ACT=1 and r<0 then r=0; output = clamp(r, XMIN, XMAX).
REQ-018 Stage 1 SHALL compute H1 (N1) and H2 (N2) from X1..X4 and register them with flag v1 on input handshake (valid & ready).
REQ-019 Stage 2 SHALL compute N3 from registered H1, H2 and register the result into Y with flag v2; valid_out = v2.
REQ-020 Stage 2 advances when v1 & (~v2 | ready_out); stage 1 loads when valid & ready.
REQ-021 ready = ~v1 | ~v2 | ready_out (combinational; full throughput of one sample per cycle).
REQ-022 Latency: result of a sample accepted at edge k appears with valid_out=1 after edge k+1 when not stalled.
REQ-023 While valid_out & ~ready_out, Y and valid_out SHALL hold; when both stages full and ready_out=0, ready=0 and no data is lost or overwritten.
REQ-024 Simultaneous output accept and stage-1 transfer in one cycle SHALL replace Y without a bubble; v2 clears only on accept with no incoming stage-1 data.
REQ-025 Simultaneous input accept and stage-1 drain SHALL reload stage 1, v1 stays 1.
REQ-026 out_count SHALL increment by 1 on every valid_out & ready_out cycle, wrapping 65535 -> 0.
REQ-027 Inputs SHALL be ignored when valid=0; Y is don't-care while valid_out=0.

Reset
REQ-028 arst=1 SHALL immediately clear v1, v2 (valid_out=0), Y=0, H1=H2=0, out_count=0; ready=1 during and after reset.
REQ-029 arst asserted mid-operation SHALL discard all in-flight samples; first result after release comes only from a newly accepted sample.

Verification
REQ-030 Defaults, ACT=0, X=(0,0,0,0), ready_out=1 -> H1=98, H2=-64, Y=127 (saturated from 179) two cycles later, out_count=1.
REQ-031 Defaults, ACT=0, X=(127,0,0,0) -> H1=-16, H2=38, Y=44.
REQ-032 ACT=1, X=(127,0,0,0) -> H1=0, H2=38, Y=54.
REQ-033 Stream 4 back-to-back samples with ready_out=1 -> ready stays 1, 4 results on consecutive cycles, out_count=4.
REQ-034 ready_out=0 with 3 samples offered -> 2 accepted, ready=0, Y held stable; release ready_out -> results in order, none lost or duplicated.
REQ-035 Preload out_count to 65535 via 65535 deliveries, deliver one more -> out_count=0; pulse arst with both stages full -> valid_out=0, out_count=0 within the same cycle.
